// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : N-channel PWM generator with one shared period counter,
//            per-channel duty, run-time edge/centre alignment and
//            shadow/active double buffering so updates only take effect
//            at a period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi #(
    parameter int NCH        = 4,
    parameter int CW         = 8,
    parameter int DEF_PERIOD = 9,
    parameter int DEF_DUTY   = 0
) (
    input  logic                   clk,
    input  logic                   rst,        // asynchronous, active-low
    input  logic                   en,
    input  logic                   center,
    input  logic                   period_wr,
    input  logic [CW-1:0]          period_in,
    input  logic                   duty_wr,
    input  logic [$clog2(NCH)-1:0] duty_ch,
    input  logic [CW-1:0]          duty_in,
    output logic [NCH-1:0]         pwm_out,
    output logic                   cyc_start
);

    localparam int            CHW         = $clog2(NCH);
    localparam logic [CW-1:0] C_DEF_P     = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] C_DEF_D     = CW'(DEF_DUTY);
    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic          C_DIR_UP    = 1'b0;
    localparam logic          C_DIR_DN    = 1'b1;
    localparam logic          C_MODE_EDGE = 1'b0;

    // Shadow (software-visible) copies
    logic [CW-1:0] r_sh_p;
    logic [CW-1:0] r_sh_d [NCH];
    // Active copies governing the period in progress
    logic [CW-1:0] r_act_p;
    logic [CW-1:0] r_act_d [NCH];
    logic          r_act_mode;
    // Shared counter and its direction (only meaningful in centre mode)
    logic [CW-1:0] r_cnt;
    logic          r_dir;
    // Registered outputs
    logic [NCH-1:0] r_pwm;
    logic           r_cyc;

    // Next-state values of the shadows, so a write in a boundary cycle
    // reaches the active set in that same cycle.
    logic [CW-1:0] w_sh_p_nxt;
    logic [CW-1:0] w_sh_d_nxt [NCH];
    logic          w_bound;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_dir_nxt;

    // Shadow write decode; out-of-range channel indices match no channel
    always_comb begin
        w_sh_p_nxt = period_wr ? period_in : r_sh_p;
        for (int i = 0; i < NCH; i++) begin
            w_sh_d_nxt[i] = (duty_wr && (duty_ch == CHW'(i))) ? duty_in : r_sh_d[i];
        end
    end

    // Last cycle of the current period
    always_comb begin
        w_bound = 1'b0;
        if (r_act_mode == C_MODE_EDGE) begin
            w_bound = (r_cnt == r_act_p);
        end else if (r_act_p <= C_ONE) begin
            // degenerate centre periods never turn around
            w_bound = (r_cnt == r_act_p);
        end else begin
            w_bound = (r_cnt == C_ONE) && (r_dir == C_DIR_DN);
        end
    end

    // Counter sequencing; the counter never exceeds the active period
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (w_bound) begin
            w_cnt_nxt = '0;
            w_dir_nxt = C_DIR_UP;
        end else if (r_act_mode == C_MODE_EDGE) begin
            w_cnt_nxt = r_cnt + C_ONE;
        end else if (r_dir == C_DIR_UP) begin
            if (r_cnt == r_act_p) begin
                w_cnt_nxt = r_cnt - C_ONE;
                w_dir_nxt = C_DIR_DN;
            end else begin
                w_cnt_nxt = r_cnt + C_ONE;
            end
        end else begin
            w_cnt_nxt = r_cnt - C_ONE;
        end
    end

    // Shadow registers accept writes every cycle, enabled or not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_p <= C_DEF_P;
            for (int i = 0; i < NCH; i++) begin
                r_sh_d[i] <= C_DEF_D;
            end
        end else begin
            r_sh_p <= w_sh_p_nxt;
            for (int i = 0; i < NCH; i++) begin
                r_sh_d[i] <= w_sh_d_nxt[i];
            end
        end
    end

    // Counter and active set: reload on boundary, track shadow while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_dir      <= C_DIR_UP;
            r_act_p    <= C_DEF_P;
            r_act_mode <= C_MODE_EDGE;
            for (int i = 0; i < NCH; i++) begin
                r_act_d[i] <= C_DEF_D;
            end
        end else if (!en || w_bound) begin
            r_cnt      <= '0;
            r_dir      <= C_DIR_UP;
            r_act_p    <= w_sh_p_nxt;
            r_act_mode <= center;
            for (int i = 0; i < NCH; i++) begin
                r_act_d[i] <= w_sh_d_nxt[i];
            end
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    // Outputs registered from the current count and active duties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= '0;
            r_cyc <= 1'b0;
        end else if (!en) begin
            r_pwm <= '0;
            r_cyc <= 1'b0;
        end else begin
            // cnt==0 only ever occurs as the first count of a period
            r_cyc <= (r_cnt == '0);
            for (int i = 0; i < NCH; i++) begin
                r_pwm[i] <= (r_cnt < r_act_d[i]);
            end
        end
    end

    assign pwm_out   = r_pwm;
    assign cyc_start = r_cyc;

endmodule
`default_nettype wire
